// File: rtl/prefetch_fetch_unit.sv
// Instruction fetch stage: request/grant imem port, DEPTH-entry prefetch queue, redirect flush, sticky halt.
// Optional FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module prefetch_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] HALT_WORD = 32'hFC000000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic            halted
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [XLEN-1:0] q_instr_q [DEPTH];
    logic [XLEN-1:0] q_instr_d [DEPTH];
    logic [XLEN-1:0] q_pc_q [DEPTH];
    logic [XLEN-1:0] q_pc_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            inflight_q, inflight_d;
    logic            halted_q, halted_d;

    logic            rsp_ok, byp, pop, pop_q, push, grant, halt_set, flush;
    logic [AW+1:0]   used, limit;
    logic [XLEN-1:0] head_instr, head_pc;
    logic            unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    always_comb begin
        rsp_ok = inflight_q && !redirect_valid && !halted_q;
`ifdef FETCH_BYPASS_EN
        byp = rsp_ok && (count_q == '0);
`else
        byp = 1'b0;
`endif
        head_instr = byp ? imem_rdata : q_instr_q[rd_ptr_q];
        head_pc    = byp ? tag_pc_q   : q_pc_q[rd_ptr_q];

        if_valid    = !reset && !halted_q && !redirect_valid && ((count_q != '0) || byp);
        if_instr    = if_valid ? head_instr : '0;
        if_pc       = if_valid ? head_pc : '0;
        if_pc_plus4 = if_valid ? head_pc + XLEN'(4) : '0;
        halted      = halted_q;

        pop   = if_valid && if_ready;
        pop_q = pop && !byp;
        // A bypassed word that decode takes this cycle never touches the queue
        push  = rsp_ok && !(byp && pop);

        // Credit freed by a pop this cycle may be spent on a new request immediately
        used     = (AW+2)'(count_q) + (AW+2)'(inflight_q);
        limit    = (AW+2)'(DEPTH) + (AW+2)'(pop);
        imem_req  = !reset && !halted_q && !redirect_valid && (used < limit);
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;

        halt_set = pop && (if_instr == HALT_WORD);
        flush    = redirect_valid || halted_q || halt_set;

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid && !halted_q)
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        else if (grant)
            fetch_pc_d = fetch_pc_q + XLEN'(4);

        tag_pc_d   = grant ? fetch_pc_q : tag_pc_q;
        inflight_d = grant;
        halted_d   = halted_q || halt_set;

        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                q_instr_d[wr_ptr_q] = imem_rdata;
                q_pc_d[wr_ptr_q]    = tag_pc_q;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop_q)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    // Queue storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
    end
endmodule

// File: doc/prefetch_fetch_unit.md
# prefetch_fetch_unit

Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. It replaces the single-instruction fetch path with a request/grant instruction-memory port, a DEPTH-entry prefetch queue, and a valid/ready handshake into the IF/ID boundary. It also provides branch/jump redirect with queue flush and in-flight discard, plus sticky halt detection. It sits between instruction memory and the decode stage and owns the fetch PC.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: fetch PC after reset.
- HALT_WORD, 32'hFC000000: instruction encoding that halts fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, low 2 bits always 0.
- imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt.
- imem_rdata  in  XLEN  instruction word, valid exactly one cycle after acceptance.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  new fetch target; low 2 bits ignored.
- if_valid  out  1  queue head valid to decode.
- if_ready  in  1  decode accepts (low = hazard stall).
- if_instr  out  XLEN  head instruction; 0 when if_valid=0.
- if_pc  out  XLEN  head address; 0 when if_valid=0.
- if_pc_plus4  out  XLEN  if_pc+4 mod 2^XLEN; 0 when if_valid=0.
- halted  out  1  sticky halt flag.

## Operation
- State: fetch_pc, queue (DEPTH × {instr, pc}), rd/wr pointers (wrap mod DEPTH), count (0..DEPTH), inflight (0/1), halted.
- Issue: imem_req = !halted && !redirect_valid && (count + inflight < DEPTH). On grant: fetch_pc += 4, inflight set, and the pc of the request is recorded for tagging.
- Response: in the cycle after a grant, imem_rdata and the tagged pc are pushed into the queue, unless redirect or halt discards them. A push and a pop may occur in the same cycle; count is unchanged.
- Pop: when if_valid && if_ready; the rd pointer advances.
- Redirect (highest priority after reset):
  - In the redirect cycle, if_valid=0, no pop, no request.
  - Any response arriving in the redirect cycle is discarded.
  - The queue is flushed (count=0, pointers equal) and fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
- Halt: popping an instruction equal to HALT_WORD sets halted on the next edge. While halted:
  - imem_req=0 and if_valid=0.
  - The queue is flushed and an arriving response is discarded.
  - redirect_valid is ignored.
  - Only reset clears halted.
- Credit rule guarantees no overflow; a push never occurs at count=DEPTH without a simultaneous pop.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr/if_pc/if_pc_plus4=0, halted=0, count=0, inflight=0.
- First request is asserted in the cycle after reset deasserts.
- Grant at t → rdata at t+1 → if_valid at t+2 (registered queue head). Bypass build: if_valid at t+1.
- Redirect at t → imem_req with new pc at t+1 → if_valid at t+3 (bypass: t+2).
- Steady state with imem_gnt=1 and if_ready=1: one instruction per cycle, for any DEPTH ≥2.
- if_ready low: the queue fills to DEPTH, then imem_req drops. It re-asserts in the cycle a pop frees credit.
- Reset mid-operation: all state returns to reset values on that edge, and any in-flight response is dropped.

## Configuration
- FETCH_BYPASS_EN defined: when count=0 and a response arrives (no redirect/halt), if_valid=1 that same cycle, driven from imem_rdata and the tagged pc.
  - If if_ready=1, the word is consumed and not written.
  - If if_ready=0, it is written to the queue as normal.
  - HALT_WORD detection also applies to bypassed words.
- Undefined: every response is written to the queue first; if_valid is driven from registered state only.

## Test plan
- Reset, RESET_PC=0, gnt=1, ready=1, memory returns addr as data → if_pc sequence 0,4,8,… one per cycle from cycle 2 (cycle 1 with bypass); if_pc_plus4=if_pc+4.
- if_ready=0 for 10 cycles, DEPTH=4 → exactly 4 grants, then imem_req=0. Release ready → heads 0,4,8,12 in order and requests resume; no loss or duplication.
- redirect_valid with redirect_pc=0x103 while one request is in flight and 3 words are queued → the in-flight word is discarded and the queue is emptied. Next imem_addr=0x100; the first if_pc after the redirect is 0x100.
- imem_gnt toggling pseudo-randomly with ready=1 → if_pc strictly increases by 4; every instruction is delivered exactly once.
- Memory word 0xFC000000 at addr 0x20 → after it is popped, halted=1 and imem_req=0 and if_valid=0 permanently. Redirect has no effect; reset clears halted and fetch restarts at RESET_PC.
- Reset asserted mid-stream with inflight=1 and count=3 → next cycle all outputs are at reset values and the late response is not enqueued.
